// File: rtl/bit_deserializer.sv
// ---------------------------------------------------------------------------
// bit_deserializer
//
// Serial-in / parallel-out word assembler. Takes one bit on each clock where
// serial_valid is high and builds DATA_WIDTH-bit words. Each completed word is
// presented on a registered valid/ready output. If a word completes while the
// previous one has not been taken, the new word is dropped and a sticky
// overflow flag is raised.
//
// Parameters
//   DATA_WIDTH       word width in bits (>= 2)
//   SHIFT_DIRECTION  1: first received bit ends up in the LSB (shift right)
//                    0: first received bit ends up in the MSB (shift left)
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   serial_in     in   serial data bit
//   serial_valid  in   serial_in is valid this cycle
//   frame_sync    in   start a new word, discarding any partial word
//   data_out      out  assembled word (registered)
//   data_valid    out  data_out holds an unconsumed word
//   data_ready    in   consumer takes data_out when data_valid & data_ready
//   bit_count     out  bits collected in the current partial word
//   overflow      out  sticky: a completed word was dropped
//   overflow_clr  in   clears overflow (a simultaneous new drop wins)
// ---------------------------------------------------------------------------
module bit_deserializer #(
    parameter int DATA_WIDTH      = 8,
    parameter int SHIFT_DIRECTION = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    input  logic                          serial_valid,
    input  logic                          frame_sync,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_count,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] fresh;
    logic                  complete;
    logic                  accept;

    // The register contents after shifting in the current bit. "fresh" is the
    // same shift applied to an empty register, used when frame_sync starts a
    // new word so that no stale bits from the discarded partial word remain.
    always_comb begin
        shifted = '0;
        fresh   = '0;
        if (SHIFT_DIRECTION != 0) begin
            shifted = {serial_in, sr[DATA_WIDTH-1:1]};
            fresh   = {serial_in, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            shifted = {sr[DATA_WIDTH-2:0], serial_in};
            fresh   = {{(DATA_WIDTH-1){1'b0}}, serial_in};
        end
    end

    // A word completes on the last bit of a frame, unless frame_sync arrives in
    // the same cycle: the sync restarts framing and the word is abandoned.
    assign complete = serial_valid && !frame_sync && (bit_count == LAST_BIT);
    assign accept   = data_valid && data_ready;

    // Shift register and bit counter. bit_count wraps to 0 on completion, so it
    // never reaches DATA_WIDTH; gaps (serial_valid low) simply hold state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            bit_count <= '0;
        end else if (frame_sync) begin
            sr        <= serial_valid ? fresh : '0;
            bit_count <= serial_valid ? CW'(1) : '0;
        end else if (serial_valid) begin
            sr        <= shifted;
            bit_count <= complete ? '0 : bit_count + CW'(1);
        end
    end

    // Output word register. A completed word is loaded whenever the output
    // slot is empty or being emptied this cycle, which gives back-to-back
    // words without a bubble. Otherwise the slot only clears on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (complete && (!data_valid || data_ready)) begin
            data_out   <= shifted;
            data_valid <= 1'b1;
        end else if (accept) begin
            data_valid <= 1'b0;
        end
    end

    // Sticky overflow: set when a completed word finds the slot still occupied
    // and not being taken. Setting has priority over a same-cycle clear so an
    // event is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (complete && data_valid && !data_ready) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// ---------------------------------------------------------------------------
// tb_bit_deserializer
//
// Directed bench for bit_deserializer at DATA_WIDTH=8. Two instances share
// all inputs: one shifting left (first bit -> MSB), one shifting right
// (first bit -> LSB). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, so every sample reflects exactly
// the edge just taken.
// ---------------------------------------------------------------------------
module tb_bit_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       serial_valid;
    logic       frame_sync;
    logic       data_ready;
    logic       overflow_clr;

    logic [7:0] data_out_l, data_out_r;
    logic       data_valid_l, data_valid_r;
    logic [2:0] bit_count_l, bit_count_r;
    logic       overflow_l, overflow_r;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    bit_deserializer #(.DATA_WIDTH(8), .SHIFT_DIRECTION(0)) dut_l (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
        .frame_sync(frame_sync), .data_out(data_out_l), .data_valid(data_valid_l),
        .data_ready(data_ready), .bit_count(bit_count_l), .overflow(overflow_l),
        .overflow_clr(overflow_clr)
    );

    bit_deserializer #(.DATA_WIDTH(8), .SHIFT_DIRECTION(1)) dut_r (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
        .frame_sync(frame_sync), .data_out(data_out_r), .data_valid(data_valid_r),
        .data_ready(data_ready), .bit_count(bit_count_r), .overflow(overflow_r),
        .overflow_clr(overflow_clr)
    );

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        frame_sync   = 1'b0;
        overflow_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Sends b[7] first down to b[0], back to back, then drops serial_valid.
    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            serial_valid = 1'b1;
            serial_in    = b[i];
            tick();
        end
        serial_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        data_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_compared++;
        if (data_out_l !== 8'h00 || data_valid_l !== 1'b0 || bit_count_l !== 3'd0 || overflow_l !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_l: got out=%h v=%b bc=%0d ovf=%b expected 00/0/0/0",
                     data_out_l, data_valid_l, bit_count_l, overflow_l);
        end
        n_compared++;
        if (data_out_r !== 8'h00 || data_valid_r !== 1'b0 || bit_count_r !== 3'd0 || overflow_r !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_r: got out=%h v=%b bc=%0d ovf=%b expected 00/0/0/0",
                     data_out_r, data_valid_r, bit_count_r, overflow_r);
        end
    endtask

    // T1: shift-left instance, bits 1,0,1,1,0,0,1,0 -> B2, valid for one cycle.
    task automatic test_shift_left();
        logic [7:0] pat = 8'hB2;
        do_reset();
        data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            serial_valid = 1'b1;
            serial_in    = pat[7-i];
            tick();
            if (i < 7) begin
                n_compared++;
                if (data_valid_l !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL t1_early_valid bit %0d: got %b expected 0", i, data_valid_l);
                end
            end
        end
        serial_valid = 1'b0;
        n_compared++;
        if (data_valid_l !== 1'b1 || data_out_l !== 8'hB2) begin
            n_mismatched++;
            $display("[TB] FAIL t1_word: got v=%b out=%h expected 1/b2", data_valid_l, data_out_l);
        end
        tick();
        n_compared++;
        if (data_valid_l !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL t1_valid_drop: got %b expected 0", data_valid_l);
        end
    endtask

    // T2: shift-right instance, same bits -> 4D; bit_count walks 0..7 then 0.
    task automatic test_shift_right();
        logic [7:0] pat = 8'hB2;
        logic [2:0] exp_bc;
        do_reset();
        data_ready = 1'b1;
        n_compared++;
        if (bit_count_r !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL t2_bc_start: got %0d expected 0", bit_count_r);
        end
        for (int i = 0; i < 8; i++) begin
            serial_valid = 1'b1;
            serial_in    = pat[7-i];
            tick();
            exp_bc = 3'((i + 1) % 8);
            n_compared++;
            if (bit_count_r !== exp_bc) begin
                n_mismatched++;
                $display("[TB] FAIL t2_bc bit %0d: got %0d expected %0d", i, bit_count_r, exp_bc);
            end
        end
        serial_valid = 1'b0;
        n_compared++;
        if (data_valid_r !== 1'b1 || data_out_r !== 8'h4D) begin
            n_mismatched++;
            $display("[TB] FAIL t2_word: got v=%b out=%h expected 1/4d", data_valid_r, data_out_r);
        end
        tick();
    endtask

    // T3: shift-left with a gap after every bit; bit_count must hold in gaps.
    task automatic test_gaps();
        logic [7:0] pat = 8'hB2;
        logic [2:0] exp_bc;
        do_reset();
        data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            serial_valid = 1'b1;
            serial_in    = pat[7-i];
            tick();
            exp_bc = 3'((i + 1) % 8);
            if (i == 7) begin
                n_compared++;
                if (data_valid_l !== 1'b1 || data_out_l !== 8'hB2) begin
                    n_mismatched++;
                    $display("[TB] FAIL t3_word: got v=%b out=%h expected 1/b2", data_valid_l, data_out_l);
                end
            end
            serial_valid = 1'b0;
            serial_in    = ~serial_in;
            tick();
            n_compared++;
            if (bit_count_l !== exp_bc) begin
                n_mismatched++;
                $display("[TB] FAIL t3_gap_hold bit %0d: got %0d expected %0d", i, bit_count_l, exp_bc);
            end
        end
    endtask

    // T4: consumer stalled; second word dropped with overflow. The drop
    // coincides with overflow_clr, and the set must win.
    task automatic test_overflow();
        logic [7:0] ones = 8'hFF;
        do_reset();
        data_ready = 1'b0;
        send_byte(8'hB2);
        for (int i = 0; i < 8; i++) begin
            serial_valid = 1'b1;
            serial_in    = ones[7-i];
            overflow_clr = (i == 7);
            tick();
            if (i == 6) begin
                n_compared++;
                if (overflow_l !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL t4_ovf_early: got %b expected 0", overflow_l);
                end
            end
        end
        idle_inputs();
        n_compared++;
        if (data_out_l !== 8'hB2 || data_valid_l !== 1'b1 || overflow_l !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL t4_drop_l: got out=%h v=%b ovf=%b expected b2/1/1",
                     data_out_l, data_valid_l, overflow_l);
        end
        n_compared++;
        if (data_out_r !== 8'h4D || overflow_r !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL t4_drop_r: got out=%h ovf=%b expected 4d/1", data_out_r, overflow_r);
        end
        data_ready = 1'b1;
        tick();
        n_compared++;
        if (data_valid_l !== 1'b0 || overflow_l !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL t4_accept: got v=%b ovf=%b expected 0/1", data_valid_l, overflow_l);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        n_compared++;
        if (overflow_l !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL t4_clr: got %b expected 0", overflow_l);
        end
    endtask

    // T5: junk bits, then frame_sync with the first bit of A5 (a bit
    // palindrome, so both instances expect A5). The junk must not complete.
    task automatic test_frame_sync();
        logic [7:0] pat = 8'hA5;
        do_reset();
        data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serial_valid = 1'b1;
            serial_in    = 1'b1;
            tick();
        end
        n_compared++;
        if (bit_count_l !== 3'd3) begin
            n_mismatched++;
            $display("[TB] FAIL t5_junk_bc: got %0d expected 3", bit_count_l);
        end
        for (int i = 0; i < 8; i++) begin
            serial_valid = 1'b1;
            serial_in    = pat[7-i];
            frame_sync   = (i == 0);
            tick();
            if (i == 0) begin
                n_compared++;
                if (bit_count_l !== 3'd1) begin
                    n_mismatched++;
                    $display("[TB] FAIL t5_sync_bc: got %0d expected 1", bit_count_l);
                end
            end
            if (i < 7) begin
                n_compared++;
                if (data_valid_l !== 1'b0 || data_valid_r !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL t5_no_junk_word bit %0d: got %b/%b expected 0/0",
                             i, data_valid_l, data_valid_r);
                end
            end
        end
        idle_inputs();
        n_compared++;
        if (data_valid_l !== 1'b1 || data_out_l !== 8'hA5 || data_out_r !== 8'hA5) begin
            n_mismatched++;
            $display("[TB] FAIL t5_word: got v=%b out_l=%h out_r=%h expected 1/a5/a5",
                     data_valid_l, data_out_l, data_out_r);
        end
        tick();
    endtask

    // frame_sync on the would-be last bit: no word, counter restarts at 1.
    task automatic test_sync_at_last();
        logic [7:0] pat = 8'h3C;
        do_reset();
        data_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            serial_valid = 1'b1;
            serial_in    = 1'b1;
            tick();
        end
        serial_in  = pat[7];
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        n_compared++;
        if (data_valid_l !== 1'b0 || bit_count_l !== 3'd1) begin
            n_mismatched++;
            $display("[TB] FAIL sync_last: got v=%b bc=%0d expected 0/1", data_valid_l, bit_count_l);
        end
        for (int i = 6; i >= 0; i--) begin
            serial_valid = 1'b1;
            serial_in    = pat[i];
            tick();
        end
        idle_inputs();
        n_compared++;
        if (data_valid_l !== 1'b1 || data_out_l !== 8'h3C || data_out_r !== 8'h3C) begin
            n_mismatched++;
            $display("[TB] FAIL sync_last_word: got v=%b out_l=%h out_r=%h expected 1/3c/3c",
                     data_valid_l, data_out_l, data_out_r);
        end
        tick();
    endtask

    // Completion in the same cycle the pending word is accepted: the new
    // word replaces it with valid held high and no overflow.
    task automatic test_back_to_back();
        logic [7:0] pat = 8'h0F;
        do_reset();
        data_ready = 1'b0;
        send_byte(8'hB2);
        for (int i = 0; i < 8; i++) begin
            serial_valid = 1'b1;
            serial_in    = pat[7-i];
            data_ready   = (i == 7);
            tick();
        end
        idle_inputs();
        data_ready = 1'b0;
        n_compared++;
        if (data_valid_l !== 1'b1 || data_out_l !== 8'h0F || overflow_l !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_l: got v=%b out=%h ovf=%b expected 1/0f/0",
                     data_valid_l, data_out_l, overflow_l);
        end
        n_compared++;
        if (data_out_r !== 8'hF0) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_r: got out=%h expected f0", data_out_r);
        end
    endtask

    // T6: reset with a word pending, overflow set and 5 bits collected.
    task automatic test_reset_midword();
        do_reset();
        data_ready = 1'b0;
        send_byte(8'hB2);
        send_byte(8'hFF);
        for (int i = 0; i < 5; i++) begin
            serial_valid = 1'b1;
            serial_in    = 1'b1;
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_compared++;
        if (data_valid_l !== 1'b0 || bit_count_l !== 3'd0 || overflow_l !== 1'b0 || data_out_l !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL t6_reset: got v=%b bc=%0d ovf=%b out=%h expected 0/0/0/00",
                     data_valid_l, bit_count_l, overflow_l, data_out_l);
        end
        data_ready = 1'b1;
        send_byte(8'hB2);
        n_compared++;
        if (data_valid_l !== 1'b1 || data_out_l !== 8'hB2 || data_out_r !== 8'h4D) begin
            n_mismatched++;
            $display("[TB] FAIL t6_word: got v=%b out_l=%h out_r=%h expected 1/b2/4d",
                     data_valid_l, data_out_l, data_out_r);
        end
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        data_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_shift_left();
        test_shift_right();
        test_gaps();
        test_overflow();
        test_frame_sync();
        test_sync_at_last();
        test_back_to_back();
        test_reset_midword();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
